// File: rtl/tuner_row_sched.sv
// Row bring-up scheduler: searches each ring in order, assigns ascending distinct peaks,
// triggers lock on every channel, then services lock-loss interrupts round-robin.
module tuner_row_sched #(
    parameter int NUM_CHANNEL = 2,
    parameter int NUM_TARGET  = 4,
    parameter int DAC_WIDTH   = 8,
    parameter int MAX_RELOCK  = 3,
    parameter int TIMEOUT     = 4096,
    localparam int CW  = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1,
    localparam int NPW = $clog2(NUM_TARGET) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [1:0]           o_err_code,
    output logic [CW-1:0]        o_err_ch,
    output logic                 o_search_trig_val    [NUM_CHANNEL],
    input  logic                 i_search_trig_rdy    [NUM_CHANNEL],
    input  logic                 i_search_done_val    [NUM_CHANNEL],
    output logic                 o_search_done_rdy    [NUM_CHANNEL],
    input  logic [NPW-1:0]       i_num_peaks          [NUM_CHANNEL],
    input  logic [DAC_WIDTH-1:0] i_peak_tune_codes    [NUM_CHANNEL][NUM_TARGET],
    output logic [DAC_WIDTH-1:0] o_cfg_ring_tune_peak [NUM_CHANNEL],
    output logic                 o_lock_trig_val      [NUM_CHANNEL],
    input  logic                 i_lock_trig_rdy      [NUM_CHANNEL],
    input  logic                 i_lock_intr_val      [NUM_CHANNEL],
    output logic                 o_lock_intr_rdy      [NUM_CHANNEL],
    output logic                 o_lock_resume_val    [NUM_CHANNEL],
    input  logic                 i_lock_resume_rdy    [NUM_CHANNEL],
    output logic [3:0]           o_state
);
    // Handshakes: a transfer occurs on a rising edge where val and rdy are both high;
    // the FSM advances on that edge and the val/rdy output drops in the following cycle.

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SRCH_TRIG = 4'd1,
        SRCH_WAIT = 4'd2,
        ASSIGN    = 4'd3,
        LOCK_TRIG = 4'd4,
        RUN       = 4'd5,
        INTR_ACK  = 4'd6,
        RESUME    = 4'd7,
        ERR       = 4'd8
    } state_t;

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int RW  = $clog2(MAX_RELOCK + 2);

    state_t               state, state_next;
    logic [CW-1:0]        ch, ch_next;
    logic [CW-1:0]        rr_ptr;
    logic [WDW-1:0]       wd;
    logic [DAC_WIDTH-1:0] prev_code;
    logic [NPW-1:0]       num_q;
    logic [DAC_WIDTH-1:0] codes_q [NUM_TARGET];
    logic [RW-1:0]        relock_cnt [NUM_CHANNEL];
    logic [1:0]           err_code, err_code_d;
    logic [CW-1:0]        err_ch;

    logic                 peak_found;
    logic [DAC_WIDTH-1:0] peak_code;
    logic                 intr_found;
    logic [CW-1:0]        intr_ch;
    logic [RW-1:0]        relock_new;
    logic                 wd_hit;
    logic                 last_ch;

    assign wd_hit  = (wd == WDW'(TIMEOUT - 1));
    assign last_ch = (ch == CW'(NUM_CHANNEL - 1));
    assign relock_new = (relock_cnt[ch] == RW'(MAX_RELOCK + 1)) ? relock_cnt[ch]
                                                                : relock_cnt[ch] + RW'(1);

    // Lowest-index captured peak obeying the ascending-order rule.
    always_comb begin
        peak_found = 1'b0;
        peak_code  = '0;
        for (int k = 0; k < NUM_TARGET; k++) begin
            if (!peak_found && (NPW'(k) < num_q) && (ch == '0 || codes_q[k] > prev_code)) begin
                peak_found = 1'b1;
                peak_code  = codes_q[k];
            end
        end
    end

    // Round-robin scan of pending interrupts starting at rr_ptr.
    always_comb begin
        int idx;
        intr_found = 1'b0;
        intr_ch    = '0;
        idx        = 0;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CHANNEL;
            if (!intr_found && i_lock_intr_val[idx]) begin
                intr_found = 1'b1;
                intr_ch    = CW'(idx);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        err_code_d = err_code;
        case (state)
            IDLE, ERR: begin
                if (i_start) begin
                    state_next = SRCH_TRIG;
                    ch_next    = '0;
                end
            end
            SRCH_TRIG: begin
                if (i_search_trig_rdy[ch]) begin
                    state_next = SRCH_WAIT;
                end else if (wd_hit) begin
                    state_next = ERR;
                    err_code_d = 2'd2;
                end
            end
            SRCH_WAIT: begin
                if (i_search_done_val[ch]) begin
                    state_next = ASSIGN;
                end else if (wd_hit) begin
                    state_next = ERR;
                    err_code_d = 2'd2;
                end
            end
            ASSIGN: begin
                if (!peak_found) begin
                    state_next = ERR;
                    err_code_d = 2'd1;
                end else if (last_ch) begin
                    state_next = LOCK_TRIG;
                    ch_next    = '0;
                end else begin
                    state_next = SRCH_TRIG;
                    ch_next    = ch + CW'(1);
                end
            end
            LOCK_TRIG: begin
                if (i_lock_trig_rdy[ch]) begin
                    if (last_ch) begin
                        state_next = RUN;
                        ch_next    = '0;
                    end else begin
                        ch_next = ch + CW'(1);
                    end
                end else if (wd_hit) begin
                    state_next = ERR;
                    err_code_d = 2'd2;
                end
            end
            RUN: begin
                if (intr_found) begin
                    state_next = INTR_ACK;
                    ch_next    = intr_ch;
                end
            end
            INTR_ACK: begin
                if (relock_new > RW'(MAX_RELOCK)) begin
                    state_next = ERR;
                    err_code_d = 2'd3;
                end else begin
                    state_next = RESUME;
                end
            end
            RESUME: begin
                if (i_lock_resume_rdy[ch]) begin
                    state_next = RUN;
                end else if (wd_hit) begin
                    state_next = ERR;
                    err_code_d = 2'd2;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with o_state.
    logic busy_d, done_d, err_d;
    logic srch_trig_d [NUM_CHANNEL];
    logic srch_rdy_d  [NUM_CHANNEL];
    logic lock_trig_d [NUM_CHANNEL];
    logic intr_rdy_d  [NUM_CHANNEL];
    logic resume_d    [NUM_CHANNEL];

    always_comb begin
        busy_d = !(state_next == IDLE || state_next == RUN || state_next == ERR);
        done_d = (state_next == RUN);
        err_d  = (state_next == ERR);
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            srch_trig_d[i] = (state_next == SRCH_TRIG) && (ch_next == CW'(i));
            srch_rdy_d[i]  = (state_next == SRCH_WAIT) && (ch_next == CW'(i));
            lock_trig_d[i] = (state_next == LOCK_TRIG) && (ch_next == CW'(i));
            intr_rdy_d[i]  = (state_next == INTR_ACK)  && (ch_next == CW'(i));
            resume_d[i]    = (state_next == RESUME)    && (ch_next == CW'(i));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            rr_ptr    <= '0;
            wd        <= '0;
            prev_code <= '0;
            num_q     <= '0;
            err_code  <= '0;
            err_ch    <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            for (int k = 0; k < NUM_TARGET; k++) codes_q[k] <= '0;
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                relock_cnt[i]           <= '0;
                o_cfg_ring_tune_peak[i] <= '0;
                o_search_trig_val[i]    <= 1'b0;
                o_search_done_rdy[i]    <= 1'b0;
                o_lock_trig_val[i]      <= 1'b0;
                o_lock_intr_rdy[i]      <= 1'b0;
                o_lock_resume_val[i]    <= 1'b0;
            end
        end else begin
            state  <= state_next;
            ch     <= ch_next;
            o_busy <= busy_d;
            o_done <= done_d;
            o_err  <= err_d;
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                o_search_trig_val[i] <= srch_trig_d[i];
                o_search_done_rdy[i] <= srch_rdy_d[i];
                o_lock_trig_val[i]   <= lock_trig_d[i];
                o_lock_intr_rdy[i]   <= intr_rdy_d[i];
                o_lock_resume_val[i] <= resume_d[i];
            end

            // Watchdog restarts whenever a new state or channel is entered.
            if (state_next != state || ch_next != ch) begin
                wd <= '0;
            end else if (state == SRCH_TRIG || state == SRCH_WAIT ||
                         state == LOCK_TRIG || state == RESUME) begin
                wd <= wd + WDW'(1);
            end

            if ((state == IDLE || state == ERR) && i_start) begin
                err_code  <= '0;
                err_ch    <= '0;
                prev_code <= '0;
                for (int i = 0; i < NUM_CHANNEL; i++) begin
                    relock_cnt[i]           <= '0;
                    o_cfg_ring_tune_peak[i] <= '0;
                end
            end
            if (state_next == ERR && state != ERR) begin
                err_code <= err_code_d;
                err_ch   <= ch;
            end
            if (state == SRCH_WAIT && i_search_done_val[ch]) begin
                num_q <= i_num_peaks[ch];
                for (int k = 0; k < NUM_TARGET; k++) codes_q[k] <= i_peak_tune_codes[ch][k];
            end
            if (state == ASSIGN && peak_found) begin
                o_cfg_ring_tune_peak[ch] <= peak_code;
                prev_code                <= peak_code;
            end
            if (state == INTR_ACK) relock_cnt[ch] <= relock_new;
            if (state == RESUME && i_lock_resume_rdy[ch]) begin
                rr_ptr <= last_ch ? '0 : ch + CW'(1);
            end
        end
    end

    assign o_state    = state;
    assign o_err_code = err_code;
    assign o_err_ch   = err_ch;

endmodule
